// File: rtl/adc_eth_pkg.sv
// Shared types and framing constants for the ADC-to-Ethernet burst path.
package adc_eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_DATA    = 3'd2,
        ST_TRAILER = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [7:0] TRL_MAGIC = 8'h5A;

    localparam int unsigned MAGIC_LSB = 24;
    localparam int unsigned CH_LSB    = 16;
    localparam int unsigned FIELD_LSB = 0;

    function automatic logic [31:0] frame_word(input logic [7:0]  magic,
                                               input logic [7:0]  ch,
                                               input logic [15:0] field);
        logic [31:0] w;
        w = '0;
        w[MAGIC_LSB +: 8]  = magic;
        w[CH_LSB    +: 8]  = ch;
        w[FIELD_LSB +: 16] = field;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set req bit at or after ptr.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    logic [IDX_W:0] idx;

    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(N_CH)) begin
                idx = idx - (IDX_W+1)'(N_CH);
            end
            if (!any_gnt && req[idx[IDX_W-1:0]]) begin
                any_gnt = 1'b1;
                gnt_idx = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/eth_burst_arbiter.sv
// Round-robin packet sequencer draining full FWFT capture FIFOs into one TX stream.
module eth_burst_arbiter #(
    parameter int N_CH      = 4,
    parameter int DW        = 32,
    parameter int BURST_LEN = 256,
    parameter int GAP_CYC   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [N_CH-1:0]    fifo_full,
    input  logic [N_CH-1:0]    fifo_empty,
    input  logic [N_CH*DW-1:0] fifo_dout,
    output logic [N_CH-1:0]    fifo_rd_en,
    output logic [DW-1:0]      tx_data,
    output logic               tx_valid,
    output logic               tx_last,
    input  logic               tx_ready,
    output logic               busy,
    output logic [3:0]         grant_ch,
    output logic [2:0]         state
);

    import adc_eth_pkg::*;

    localparam int          IDX_W      = $clog2(N_CH);
    localparam logic [15:0] BURST_LAST = 16'(BURST_LEN);
    localparam logic [15:0] GAP_LAST   = 16'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            gap_q, gap_d;
    logic [N_CH-1:0][15:0]  seq_q, seq_d;

    logic [N_CH-1:0]        ready;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;
    logic [DW-1:0]          dout_a [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_dout
        assign dout_a[c] = fifo_dout[c*DW +: DW];
    end

    assign ready = fifo_full & ~fifo_empty;

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (ready),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .any_gnt (arb_any)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            seq_q    <= seq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        seq_d      = seq_q;
        fifo_rd_en = '0;
        tx_valid   = 1'b0;
        tx_last    = 1'b0;
        tx_data    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && arb_any) begin
                    grant_d  = arb_idx;
                    rr_ptr_d = (arb_idx == IDX_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
                    state_d  = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid      = 1'b1;
                tx_data[31:0] = frame_word(HDR_MAGIC, 8'(grant_q), seq_q[grant_q]);
                if (tx_ready) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // FWFT: an empty granted FIFO ends the burst early, possibly with zero words
                tx_valid = ~fifo_empty[grant_q];
                tx_data  = dout_a[grant_q];
                if (tx_valid && tx_ready) begin
                    fifo_rd_en[grant_q] = 1'b1;
                    cnt_d               = cnt_q + 16'd1;
                    if (cnt_d == BURST_LAST) begin
                        state_d = ST_TRAILER;
                    end
                end else if (!tx_valid) begin
                    state_d = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                tx_valid      = 1'b1;
                tx_last       = 1'b1;
                tx_data[31:0] = frame_word(TRL_MAGIC, 8'(grant_q), cnt_q);
                if (tx_ready) begin
                    seq_d[grant_q] = seq_q[grant_q] + 16'd1;
                    gap_d          = '0;
                    state_d        = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_ch = 4'(grant_q);
    assign state    = state_q;

endmodule

// File: tb/tb_eth_burst_arbiter.sv
// Directed scoreboard bench for eth_burst_arbiter with behavioural FWFT FIFO models.
module tb_eth_burst_arbiter;

    localparam int N_CH      = 4;
    localparam int DW        = 32;
    localparam int BURST_LEN = 256;
    localparam int GAP_CYC   = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               enable;
    logic [N_CH-1:0]    fifo_full;
    logic [N_CH-1:0]    fifo_empty;
    logic [N_CH*DW-1:0] fifo_dout;
    logic [N_CH-1:0]    fifo_rd_en;
    logic [DW-1:0]      tx_data;
    logic               tx_valid;
    logic               tx_last;
    logic               tx_ready;
    logic               busy;
    logic [3:0]         grant_ch;
    logic [2:0]         state;

    always #5 clk = ~clk;

    eth_burst_arbiter #(
        .N_CH      (N_CH),
        .DW        (DW),
        .BURST_LEN (BURST_LEN),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .grant_ch   (grant_ch),
        .state      (state)
    );

    logic [DW-1:0] fq [N_CH][$];
    logic [32:0]   sb [$];
    int            wr_idx [N_CH];
    int            rd_idx [N_CH];
    logic [15:0]   exp_seq [N_CH];
    int            n_vec = 0;
    int            n_err = 0;
    bit            rand_rdy = 1'b0;
    logic          rdy_level = 1'b1;
    logic [N_CH-1:0] pop_pend = '0;
    logic          prev_stall = 1'b0;
    logic [32:0]   prev_word;
    logic [32:0]   mon_exp;

    function automatic logic [31:0] word_of(input int ch, input int i);
        return {4'(ch), 12'h000, 16'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int c = 0; c < N_CH; c++) begin
            fifo_empty[c]           = (fq[c].size() == 0);
            fifo_dout[c*DW +: DW]   = (fq[c].size() != 0) ? fq[c][0] : '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            fq[ch].push_back(word_of(ch, wr_idx[ch]));
            wr_idx[ch]++;
        end
        refresh();
    endtask

    task automatic exp_pkt(input int ch, input int n, input bit trailer);
        sb.push_back({1'b0, 8'hA5, 8'(ch), exp_seq[ch]});
        for (int i = 0; i < n; i++) begin
            sb.push_back({1'b0, word_of(ch, rd_idx[ch])});
            rd_idx[ch]++;
        end
        if (trailer) begin
            sb.push_back({1'b1, 8'h5A, 8'(ch), 16'(n)});
            exp_seq[ch] = exp_seq[ch] + 16'd1;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(tx_valid),   64'd0);
        check({tag, "_last"},  64'(tx_last),    64'd0);
        check({tag, "_data"},  64'(tx_data),    64'd0);
        check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        check({tag, "_busy"},  64'(busy),       64'd0);
        check({tag, "_grant"}, 64'(grant_ch),   64'd0);
        check({tag, "_state"}, 64'(state),      64'd0);
    endtask

    // Stream monitor: samples at negedge, records pops for the FIFO models
    initial forever begin
        @(negedge clk);
        pop_pend = fifo_rd_en;
        if (rstn && prev_stall) begin
            check("stall_hold", 64'({tx_valid, tx_last, tx_data}), 64'({1'b1, prev_word}));
        end
        prev_stall = rstn && tx_valid && !tx_ready;
        prev_word  = {tx_last, tx_data};
        if (rstn && tx_valid && tx_ready) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_xfer: observed %h expected none", {tx_last, tx_data});
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check("stream", 64'({tx_last, tx_data}), 64'(mon_exp));
            end
        end
    end

    // FWFT FIFO models and tx_ready driver, updated just after the active edge
    initial forever begin
        @(posedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (pop_pend[c] && fq[c].size() != 0) begin
                void'(fq[c].pop_front());
            end
        end
        pop_pend = '0;
        tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
        refresh();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int idle;

        rstn      = 1'b0;
        enable    = 1'b0;
        fifo_full = '0;
        tx_ready  = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            wr_idx[c]  = 0;
            rd_idx[c]  = 0;
            exp_seq[c] = 16'h0000;
        end
        refresh();
        repeat (3) tick();
        check_reset_outputs("reset");
        rstn   = 1'b1;
        enable = 1'b1;
        tick();

        // Full burst then short remainder on ch1, with inter-packet gap measured
        load(1, 300);
        exp_pkt(1, BURST_LEN, 1'b1);
        exp_pkt(1, 44, 1'b1);
        fifo_full[1] = 1'b1;
        k = 0;
        while (sb.size() > 46 && k < 600) begin
            tick();
            k++;
        end
        check("t1_first_pkt_done", 64'(sb.size()), 64'd46);
        idle = 0;
        tick();
        while (!tx_valid && idle < 50) begin
            idle++;
            tick();
        end
        check("t1_gap_cycles", 64'(idle), 64'(GAP_CYC + 1));
        drain("t1_drain", 300);
        check("t1_fifo_drained", 64'(fq[1].size()), 64'd0);
        check("t1_grant", 64'(grant_ch), 64'd1);
        fifo_full[1] = 1'b0;

        // Simultaneous requesters from rr_ptr=0, then rotation past ch0
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        for (int c = 0; c < N_CH; c++) exp_seq[c] = 16'h0000;
        load(0, 20);
        load(2, 20);
        exp_pkt(0, 20, 1'b1);
        exp_pkt(2, 20, 1'b1);
        fifo_full[0] = 1'b1;
        fifo_full[2] = 1'b1;
        drain("t2_ch0_ch2", 200);
        load(0, 8);
        load(3, 8);
        exp_pkt(3, 8, 1'b1);
        exp_pkt(0, 8, 1'b1);
        fifo_full[0] = 1'b1;
        fifo_full[3] = 1'b1;
        drain("t2_ch3_then_ch0", 200);
        check("t2_grant", 64'(grant_ch), 64'd0);
        fifo_full = '0;

        // Random backpressure
        load(2, 100);
        exp_pkt(2, 100, 1'b1);
        rand_rdy = 1'b1;
        fifo_full[2] = 1'b1;
        drain("t3_random_ready", 1500);
        rand_rdy  = 1'b0;
        check("t3_fifo_drained", 64'(fq[2].size()), 64'd0);
        fifo_full = '0;

        // Early empty after 10 words
        load(1, 10);
        exp_pkt(1, 10, 1'b1);
        fifo_full[1] = 1'b1;
        drain("t4_short_pkt", 100);
        fifo_full[1] = 1'b0;

        // enable dropped mid-packet: packet completes, no further grant
        load(3, 30);
        exp_pkt(3, 30, 1'b1);
        fifo_full[3] = 1'b1;
        k = 0;
        while (fq[3].size() > 25 && k < 100) begin
            tick();
            k++;
        end
        enable = 1'b0;
        load(0, 10);
        fifo_full[0] = 1'b1;
        drain("t4_enable_off_drain", 200);
        repeat (20) tick();
        check("t4_idle_busy", 64'(busy), 64'd0);
        check("t4_grant_held", 64'(grant_ch), 64'd3);
        check("t4_no_pops", 64'(fq[0].size()), 64'd10);
        exp_pkt(0, 10, 1'b1);
        enable = 1'b1;
        drain("t4_reenable", 200);
        fifo_full = '0;
        wait_idle(50);

        // Reset in DATA after 5 words
        load(0, 20);
        exp_pkt(0, 5, 1'b0);
        fifo_full[0] = 1'b1;
        k = 0;
        while (fq[0].size() > 15 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        rstn      = 1'b0;
        rdy_level = 1'b0;
        tx_ready  = 1'b0;
        check("t5_words_before_reset", 64'(fq[0].size()), 64'd15);
        check("t5_sb_before_reset", 64'(sb.size()), 64'd0);
        @(posedge clk);
        tick();
        check_reset_outputs("t5_abort");
        rstn      = 1'b1;
        rdy_level = 1'b1;
        tx_ready  = 1'b1;
        for (int c = 0; c < N_CH; c++) exp_seq[c] = 16'h0000;
        exp_pkt(0, 15, 1'b1);
        drain("t5_after_reset", 200);
        fifo_full = '0;
        wait_idle(50);

        // ch3 sequence wrap with the counter preset to FFFF
        @(negedge clk);
        force dut.seq_q = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        @(posedge clk);
        tick();
        release dut.seq_q;
        for (int c = 0; c < N_CH; c++) exp_seq[c] = 16'h0000;
        exp_seq[3] = 16'hFFFF;
        load(3, 2);
        exp_pkt(3, 2, 1'b1);
        fifo_full[3] = 1'b1;
        drain("t6_seq_ffff", 100);
        load(3, 2);
        exp_pkt(3, 2, 1'b1);
        drain("t6_seq_wrap", 100);
        fifo_full = '0;
        wait_idle(50);

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
